bin2bcd_seq: RTL

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method. It sits directly upstream of the per-digit seven-segment decoders. It takes an unsigned binary value on a start pulse and produces DIGITS packed BCD nibbles, one per decoder input. It adds a start/busy/done handshake and saturates to all-nines on overflow, so no decoder ever sees a non-decimal nibble.

---
 rtl/bcd_pkg.sv | 38 +++
 rtl/bcd_digit_adj.sv | 17 +
 rtl/bin2bcd_seq.sv | 106 ++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared types and constant helpers for the binary-to-BCD block.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    // Wide enough for up to 16 digits; callers slice down to their own width.
    function automatic logic [63:0] all_nines(input int unsigned digits);
        logic [63:0] r;
        r = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (i < digits) begin
                r[4*i +: 4] = 4'h9;
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adj.sv
// ============================================================================
//  Module      : bcd_digit_adj
//  Description : Double-dabble digit correction: add 3 to any nibble >= 5.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_adj (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential shift-and-add-3 binary-to-BCD converter with
//                start/busy/done handshake and all-nines saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    input  logic                  iStart,
    input  logic [WIDTH-1:0]      iBin,
    output logic                  oBusy,
    output logic                  oDone,
    output logic [4*DIGITS-1:0]   oBcd,
    output logic                  oOvf
);

    localparam int          BW     = 4 * DIGITS;
    localparam int          CW     = $clog2(WIDTH + 1);
    localparam int unsigned MAXV   = pow10(DIGITS) - 1;
    localparam logic [63:0] NINES_W = all_nines(DIGITS);
    localparam logic [BW-1:0] NINES = NINES_W[BW-1:0];

    state_t              state_q;
    logic [WIDTH-1:0]    sh_q;
    logic [BW-1:0]       scr_q;
    logic [CW-1:0]       cnt_q;
    logic                ovf_q;

    logic [BW-1:0]       adj_d;
    logic [BW-1:0]       scr_d;
    logic [WIDTH-1:0]    sh_d;
    logic                sat_d;
    logic [31:0]         bin_ext_d;

    genvar k;
    generate
        for (k = 0; k < DIGITS; k++) begin : g_adj
            bcd_digit_adj u_adj (
                .digit_i (scr_q[4*k +: 4]),
                .digit_o (adj_d[4*k +: 4])
            );
        end
    endgenerate

    assign scr_d     = {adj_d[BW-2:0], sh_q[WIDTH-1]};
    assign sh_d      = {sh_q[WIDTH-2:0], 1'b0};
    assign bin_ext_d = 32'(iBin);
    // A bit falling off the top digit can only happen when the operand is
    // already out of range, so it simply reinforces the saturate decision.
    assign sat_d     = ovf_q | adj_d[BW-1];

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state_q <= IDLE;
            sh_q    <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
            oBcd    <= '0;
            oOvf    <= 1'b0;
        end else begin
            oDone <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (iStart) begin
                        sh_q    <= iBin;
                        scr_q   <= '0;
                        cnt_q   <= CW'(WIDTH);
                        ovf_q   <= (bin_ext_d > MAXV);
                        oBusy   <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    scr_q <= scr_d;
                    sh_q  <= sh_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        oBcd    <= sat_d ? NINES : scr_d;
                        oOvf    <= ovf_q;
                        oDone   <= 1'b1;
                        oBusy   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    oBusy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
